// File: rtl/kernel_host_pkg.sv
// rtl/kernel_host_pkg.sv - shared types and constants for the kernel host driver
package kernel_host_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    RB_ISSUE,
    RB_WAIT,
    RB_HOLD,
    RESP
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/kernel_host_timer.sv
// rtl/kernel_host_timer.sv - saturating RUN-cycle counter with timeout detect
module kernel_host_timer
  import kernel_host_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, holding at TIMEOUT once reached.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Asserted during the TIMEOUT-th enabled cycle, so the job aborts after exactly TIMEOUT RUN cycles.
  assign hit = en && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/kernel_host_driver.sv
// rtl/kernel_host_driver.sv - job sequencer around the generated main kernel
module kernel_host_driver
  import kernel_host_pkg::*;
#(
  parameter int ADDR_W  = 1,
  parameter int DEPTH   = 1,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_init,
  input  logic              cmd_preload,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_timeout,
  output logic              k_r_enable,
  output logic [DATA_W-1:0] k_init_i,
  output logic              k_controlArr,
  output logic              k_wen,
  output logic [ADDR_W-1:0] k_addr,
  output logic [DATA_W-1:0] k_wdata,
  input  logic [DATA_W-1:0] k_rdata,
  input  logic              k_w_enable,
  input  logic [DATA_W-1:0] k_result
);

  // One extra index bit so DEPTH == 2**ADDR_W never wraps before the end test.
  localparam int IDX_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] init_q;
  logic [DATA_W-1:0] rb_data_q;
  logic              rb_last_q;
  rsp_t              rsp_q;

  logic cmd_fire, ld_fire, rb_fire, rsp_fire;
  logic idx_end, timer_hit;

  assign idx_end = (idx_q == IDX_W'(DEPTH - 1));

  kernel_host_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_fire),
    .en    (state_q == RUN),
    .hit   (timer_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/kernel strobes; w_enable takes priority over timeout in RUN.
  always_comb begin
    state_d      = state_q;
    cmd_fire     = 1'b0;
    ld_fire      = 1'b0;
    rb_fire      = 1'b0;
    rsp_fire     = 1'b0;
    cmd_ready    = 1'b0;
    ld_ready     = 1'b0;
    rb_valid     = 1'b0;
    rsp_valid    = 1'b0;
    k_r_enable   = 1'b0;
    k_controlArr = 1'b0;
    k_wen        = 1'b0;
    k_wdata      = '0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so ready stays low while reset is held.
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          cmd_fire = 1'b1;
          state_d  = cmd_preload ? LOAD : START;
        end
      end
      LOAD: begin
        k_controlArr = 1'b1;
        ld_ready     = 1'b1;
        if (ld_valid) begin
          ld_fire = 1'b1;
          k_wen   = 1'b1;
          k_wdata = ld_data;
          if (idx_end) state_d = START;
        end
      end
      START: begin
        k_r_enable = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (k_w_enable)     state_d = RB_ISSUE;
        else if (timer_hit) state_d = RESP;
      end
      RB_ISSUE: begin
        k_controlArr = 1'b1;
        state_d      = RB_WAIT;
      end
      RB_WAIT: begin
        k_controlArr = 1'b1;
        state_d      = RB_HOLD;
      end
      RB_HOLD: begin
        k_controlArr = 1'b1;
        rb_valid     = 1'b1;
        if (rb_ready) begin
          rb_fire = 1'b1;
          state_d = rb_last_q ? RESP : RB_ISSUE;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job datapath: init value, array index, readback word and response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      init_q    <= '0;
      rb_data_q <= '0;
      rb_last_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      if (cmd_fire) begin
        init_q <= cmd_init;
        idx_q  <= '0;
      end
      if (ld_fire || (rb_fire && !rb_last_q)) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (state_q == RUN) begin
        if (k_w_enable) begin
          rsp_q.result <= k_result;
          idx_q        <= '0;
        end else if (timer_hit) begin
          rsp_q.result  <= '0;
          rsp_q.timeout <= 1'b1;
        end
      end
      if (state_q == RB_WAIT) begin
        rb_data_q <= k_rdata;
        rb_last_q <= idx_end;
      end
      if (rsp_fire) begin
        rsp_q.timeout <= 1'b0;
      end
    end
  end

  assign k_init_i    = init_q;
  assign k_addr      = idx_q[ADDR_W-1:0];
  assign rb_data     = rb_data_q;
  assign rb_last     = rb_last_q;
  assign rsp_result  = rsp_q.result;
  assign rsp_timeout = rsp_q.timeout;

endmodule
